// File: rtl/store_buffer.sv
// Write-posting store buffer for the MEM stage. Stores are queued and retired
// to D_Mem on cycles the port is not used by a load. Loads take the port
// first, and they stall only when a byte overlaps a buffered store. Load data
// is sign- or zero-extended for WB.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              St_Valid,
  input  logic [ADDR_W-1:0] St_Addr,
  input  logic [DATA_W-1:0] St_Data,
  input  logic [2:0]        St_Funct3,
  input  logic              Ld_Valid,
  input  logic [ADDR_W-1:0] Ld_Addr,
  input  logic [2:0]        Ld_Funct3,
  output logic [DATA_W-1:0] Ld_Data,
  output logic              Stall,
  output logic              Sb_Empty,
  output logic              Mem_r,
  output logic              Mem_w,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_W_Data,
  output logic [3:0]        Mem_W_Strb,
  input  logic [DATA_W-1:0] Mem_R_Data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [3:0]        strb_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [3:0]        strb_d [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic              ld_v, hazard, st_ok, full, push, pop;
  logic [ADDR_W:0]   ld_lo, ld_hi, lsz;
  logic [DATA_W-1:0] new_data;
  logic [3:0]        new_strb;

  // Load/store qualification and the hazard check. The check compares each
  // strobed byte of every valid entry against the load's byte range.
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic [ADDR_W:0]  b;
    ld_v   = Ld_Valid & ~St_Valid & ~rst;
    st_ok  = St_Valid & ~rst & (St_Funct3 == 3'b000 || St_Funct3 == 3'b001 ||
                                St_Funct3 == 3'b010);
    full   = (count_q == CNT_W'(DEPTH));
    case (Ld_Funct3)
      3'b000, 3'b100: lsz = (ADDR_W+1)'(1);
      3'b001, 3'b101: lsz = (ADDR_W+1)'(2);
      3'b010:         lsz = (ADDR_W+1)'(4);
      default:        lsz = '0;
    endcase
    ld_lo  = {1'b0, Ld_Addr};
    ld_hi  = ld_lo + lsz;
    hazard = 1'b0;
    idx    = '0;
    b      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        for (int unsigned k = 0; k < 4; k++) begin
          b = {1'b0, addr_q[idx]} + (ADDR_W+1)'(k);
          if (strb_q[idx][k] && b >= ld_lo && b < ld_hi) hazard = 1'b1;
        end
      end
    end
  end

  // Port arbitration: a hazard-free load is served first, then the head entry drains.
  always_comb begin
    Mem_r      = ld_v & ~hazard;
    pop        = ~rst & ~Mem_r & (count_q != '0);
    Mem_w      = pop;
    push       = st_ok & (~full | pop);
    Stall      = (ld_v & hazard) | (st_ok & full & ~pop);
    Sb_Empty   = (count_q == '0);
    Mem_Addr   = '0;
    Mem_W_Data = '0;
    Mem_W_Strb = '0;
    if (Mem_r) begin
      Mem_Addr = Ld_Addr;
    end else if (Mem_w) begin
      Mem_Addr   = addr_q[head_q];
      Mem_W_Data = data_q[head_q];
      Mem_W_Strb = strb_q[head_q];
    end
  end

  // Load result extension, zero when the port is not reading.
  always_comb begin
    Ld_Data = '0;
    if (Mem_r) begin
      case (Ld_Funct3)
        3'b000:  Ld_Data = {{(DATA_W-8){Mem_R_Data[7]}}, Mem_R_Data[7:0]};
        3'b001:  Ld_Data = {{(DATA_W-16){Mem_R_Data[15]}}, Mem_R_Data[15:0]};
        3'b010:  Ld_Data = Mem_R_Data;
        3'b100:  Ld_Data = {{(DATA_W-8){1'b0}}, Mem_R_Data[7:0]};
        3'b101:  Ld_Data = {{(DATA_W-16){1'b0}}, Mem_R_Data[15:0]};
        default: Ld_Data = '0;
      endcase
    end
  end

  // Entry build and next-state for pointers, count and storage.
  always_comb begin
    case (St_Funct3)
      3'b000:  begin new_strb = 4'b0001; new_data = DATA_W'(St_Data[7:0]);  end
      3'b001:  begin new_strb = 4'b0011; new_data = DATA_W'(St_Data[15:0]); end
      default: begin new_strb = 4'b1111; new_data = St_Data;                end
    endcase
    addr_d  = addr_q;
    data_d  = data_q;
    strb_d  = strb_q;
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(push);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      addr_d[tail_q] = St_Addr;
      data_d[tail_q] = new_data;
      strb_d[tail_q] = new_strb;
    end
  end

  // Pointer and count registers; reset discards all buffered stores.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are meaningless unless counted valid.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    strb_q <= strb_d;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: a queue-based reference model plus a byte-array memory.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst, St_Valid, Ld_Valid;
  logic [31:0] St_Addr, St_Data, Ld_Addr, Ld_Data, Mem_Addr, Mem_W_Data, Mem_R_Data;
  logic [2:0]  St_Funct3, Ld_Funct3;
  logic        Stall, Sb_Empty, Mem_r, Mem_w;
  logic [3:0]  Mem_W_Strb;

  store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .St_Valid(St_Valid), .St_Addr(St_Addr), .St_Data(St_Data), .St_Funct3(St_Funct3),
    .Ld_Valid(Ld_Valid), .Ld_Addr(Ld_Addr), .Ld_Funct3(Ld_Funct3), .Ld_Data(Ld_Data),
    .Stall(Stall), .Sb_Empty(Sb_Empty), .Mem_r(Mem_r), .Mem_w(Mem_w),
    .Mem_Addr(Mem_Addr), .Mem_W_Data(Mem_W_Data), .Mem_W_Strb(Mem_W_Strb),
    .Mem_R_Data(Mem_R_Data)
  );

  always #5 clk = ~clk;

  // Environment memory written by the DUT, read combinationally.
  logic [7:0] env_mem [256];
  logic [7:0] ref_mem [256];

  always_comb begin
    logic [7:0] a;
    a = Mem_Addr[7:0];
    Mem_R_Data = {env_mem[8'(a + 8'd3)], env_mem[8'(a + 8'd2)],
                  env_mem[8'(a + 8'd1)], env_mem[a]};
  end

  always @(posedge clk) begin
    if (Mem_w) begin
      for (int k = 0; k < 4; k++)
        if (Mem_W_Strb[k]) env_mem[8'(Mem_Addr[7:0] + 8'(k))] <= Mem_W_Data[8*k +: 8];
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } ent_t;
  ent_t q[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] o_ld_data;
  logic        o_stall, o_mem_r, o_mem_w, o_sb_empty;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {ref_mem[8'(b + 8'd3)], ref_mem[8'(b + 8'd2)], ref_mem[8'(b + 8'd1)], ref_mem[b]};
  endfunction

  // One cycle: drive, compare against the model, then advance the model at the edge.
  task automatic step(input logic r, input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                      input logic [2:0] sf, input logic lv, input logic [31:0] la,
                      input logic [2:0] lf);
    longint lsz, lo, elo, esz;
    logic ld, haz, e_r, e_w, e_push, e_stall, st_legal;
    logic [31:0] w, e_ld, e_addr, e_wd;
    logic [3:0] e_strb;
    ent_t ne;
    rst = r; St_Valid = sv; St_Addr = sa; St_Data = sd; St_Funct3 = sf;
    Ld_Valid = lv; Ld_Addr = la; Ld_Funct3 = lf;
    #2;
    ld = lv && !sv && !r;
    lsz = (lf == 3'b000 || lf == 3'b100) ? 1 : (lf == 3'b001 || lf == 3'b101) ? 2 :
          (lf == 3'b010) ? 4 : 0;
    lo = longint'(la);
    haz = 1'b0;
    foreach (q[i]) begin
      elo = longint'(q[i].addr);
      esz = (q[i].strb == 4'hF) ? 4 : (q[i].strb == 4'h3) ? 2 : 1;
      if (lsz > 0 && lo < elo + esz && elo < lo + lsz) haz = 1'b1;
    end
    e_r = ld && !haz;
    e_w = !r && !e_r && q.size() > 0;
    st_legal = sv && !r && (sf <= 3'b010);
    e_push = st_legal && (q.size() < 4 || e_w);
    e_stall = (ld && haz) || (st_legal && q.size() == 4 && !e_w);
    e_addr = e_r ? la : e_w ? q[0].addr : 32'h0;
    e_wd   = e_w ? q[0].data : 32'h0;
    e_strb = e_w ? q[0].strb : 4'h0;
    w = ref_word(la);
    e_ld = 32'h0;
    if (e_r) begin
      case (lf)
        3'b000: e_ld = 32'(signed'(w[7:0]));
        3'b001: e_ld = 32'(signed'(w[15:0]));
        3'b010: e_ld = w;
        3'b100: e_ld = {24'h0, w[7:0]};
        3'b101: e_ld = {16'h0, w[15:0]};
        default: e_ld = 32'h0;
      endcase
    end
    chk("stall", 32'(Stall), 32'(e_stall));
    chk("sb_empty", 32'(Sb_Empty), 32'(q.size() == 0));
    chk("mem_r", 32'(Mem_r), 32'(e_r));
    chk("mem_w", 32'(Mem_w), 32'(e_w));
    chk("mem_addr", Mem_Addr, e_addr);
    chk("mem_wdata", Mem_W_Data, e_wd);
    chk("mem_strb", 32'(Mem_W_Strb), 32'(e_strb));
    chk("ld_data", Ld_Data, e_ld);
    o_ld_data = Ld_Data; o_stall = Stall; o_mem_r = Mem_r; o_mem_w = Mem_w; o_sb_empty = Sb_Empty;
    ne.addr = sa;
    ne.strb = (sf == 3'b000) ? 4'h1 : (sf == 3'b001) ? 4'h3 : 4'hF;
    ne.data = (sf == 3'b000) ? {24'h0, sd[7:0]} : (sf == 3'b001) ? {16'h0, sd[15:0]} : sd;
    @(posedge clk);
    if (r) q.delete();
    else begin
      if (e_w) begin
        for (int k = 0; k < 4; k++)
          if (q[0].strb[k]) ref_mem[8'(q[0].addr[7:0] + 8'(k))] = q[0].data[8*k +: 8];
        void'(q.pop_front());
      end
      if (e_push) q.push_back(ne);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 3'b000);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    step(1'b0, 1'b1, a, d, f, 1'b0, 32'h0, 3'b000);
  endtask

  task automatic ldq(input logic [31:0] a, input logic [2:0] f);
    step(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, a, f);
  endtask

  initial begin
    int nw, bad;
    logic [2:0] fs [6];
    fs[0] = 3'b000; fs[1] = 3'b001; fs[2] = 3'b010;
    fs[3] = 3'b100; fs[4] = 3'b101; fs[5] = 3'b011;
    for (int i = 0; i < 256; i++) begin env_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    rst = 1'b1; St_Valid = 1'b0; St_Addr = '0; St_Data = '0; St_Funct3 = '0;
    Ld_Valid = 1'b0; Ld_Addr = '0; Ld_Funct3 = '0;
    repeat (2) @(posedge clk);
    #1;
    idle(1);
    chk("rst_stall", 32'(o_stall), 32'h0);
    chk("rst_empty", 32'(o_sb_empty), 32'h1);
    chk("rst_ld_data", o_ld_data, 32'h0);

    // Single word store drains in exactly one write cycle.
    st(32'h10, 32'hDEADBEEF, 3'b010);
    nw = 0;
    for (int i = 0; i < 3; i++) begin idle(1); nw += int'(o_mem_w); end
    chk("sw_writes", 32'(nw), 32'h1);
    chk("sw_empty", 32'(o_sb_empty), 32'h1);

    // Byte store with overlapping load.
    st(32'h21, 32'h1FF, 3'b000);
    ldq(32'h21, 3'b100);
    chk("sb_hazard_stall", 32'(o_stall), 32'h1);
    ldq(32'h21, 3'b100);
    chk("lbu_stall", 32'(o_stall), 32'h0);
    chk("lbu_data", o_ld_data, 32'h000000FF);
    ldq(32'h21, 3'b000);
    chk("lb_data", o_ld_data, 32'hFFFFFFFF);

    // Store chain with pops, then a non-overlapping load.
    st(32'h80, 32'h11111111, 3'b010);
    st(32'h84, 32'h22222222, 3'b010);
    chk("pushpop_stall", 32'(o_stall), 32'h0);
    chk("pushpop_memw", 32'(o_mem_w), 32'h1);
    st(32'h88, 32'h33333333, 3'b010);
    st(32'h8C, 32'h44444444, 3'b010);
    ldq(32'h40, 3'b010);
    chk("nohaz_stall", 32'(o_stall), 32'h0);
    chk("nohaz_memr", 32'(o_mem_r), 32'h1);
    idle(1);
    chk("drain_resume", 32'(o_mem_w), 32'h1);
    idle(2);

    // Halfword hazard boundaries.
    st(32'h32, 32'hABCD, 3'b001);
    ldq(32'h30, 3'b010);
    chk("sh_overlap_stall", 32'(o_stall), 32'h1);
    ldq(32'h30, 3'b010);
    chk("lw30_data", o_ld_data, 32'hABCD0000);
    st(32'h32, 32'h1234, 3'b001);
    ldq(32'h34, 3'b010);
    chk("sh_adjacent_stall", 32'(o_stall), 32'h0);
    idle(2);

    // Reset discards the buffered store.
    st(32'h50, 32'h12345678, 3'b010);
    step(1'b1, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 3'b000);
    chk("rst_no_write", 32'(o_mem_w), 32'h0);
    idle(3);
    chk("rst_mem_untouched", {env_mem[8'h53], env_mem[8'h52], env_mem[8'h51], env_mem[8'h50]}, 32'h0);
    chk("rst_after_empty", 32'(o_sb_empty), 32'h1);

    // Random traffic in a small window to provoke overlaps.
    for (int i = 0; i < 400; i++) begin
      int op;
      logic [31:0] a;
      op = int'($urandom_range(0, 99));
      a  = 32'h60 + 32'($urandom_range(0, 31));
      if (op < 2)       step(1'b1, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 3'b000);
      else if (op < 40) st(a, $urandom, fs[$urandom_range(0, 2)] | ((op < 5) ? 3'b011 : 3'b000));
      else if (op < 80) ldq(a, fs[$urandom_range(0, 5)]);
      else if (op < 83) step(1'b0, 1'b1, a, $urandom, 3'b010, 1'b1, a, 3'b010);
      else              idle(1);
    end
    idle(6);
    bad = 0;
    for (int i = 0; i < 256; i++) if (env_mem[i] !== ref_mem[i]) bad++;
    chk("final_memory", 32'(bad), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
